freq_meter: RTL and testbench
=============================

// Module: freq_meter
// PURPOSE
//  Measures a slow on-chip or off-chip square wave, such as a divided clock from the frequency dividers.
//  Two measurements, both in clk cycles:
//   - gated count: rising edges of sig_in within a fixed window of GATE_CYCLES clk cycles;
//   - period: clk cycles between successive rising edges of sig_in.
//  Sits beside the divider blocks as their self-check and readout path.
// PARAMETERS
//  GATE_CYCLES  1024  window length in clk cycles (>=2)
//  CNT_W        16    width of count/period; must satisfy 2**CNT_W >= GATE_CYCLES
//  SYNC_STAGES  2     synchronizer flops on sig_in (>=2)
// PORTS
//  clk           in   1      clock, rising edge
//  rst           in   1      reset, synchronous, active-high
//  en            in   1      1 = measure; 0 = idle/abort
//  sig_in        in   1      asynchronous signal under test
//  count         out  CNT_W  rising edges in last completed window
//  meas_valid    out  1      1-cycle pulse: count/no_signal updated
//  no_signal     out  1      last completed window saw 0 edges
//  period        out  CNT_W  clk cycles between last two rising edges
//  period_valid  out  1      1-cycle pulse: period/period_ovf updated
//  period_ovf    out  1      last period saturated (period = all-ones)
// BEHAVIOUR
//  Reset:
//   - all outputs 0, FSM=IDLE, synchronizer and edge-history flops 0, period un-armed;
//   - rst overrides en and any in-flight window.
//  Input path:
//   - sig_in passes SYNC_STAGES flops, then one history flop s_d;
//   - rise = s_sync & ~s_d, i.e. 1 cycle per low->high transition;
//   - max 1 rise every 2 cycles;
//   - the input path runs regardless of en.
//  FSM states: IDLE, GATE.
//   - IDLE->GATE on the edge sampling en=1; that edge clears edge_cnt and loads gate_cnt=GATE_CYCLES-1;
//   - GATE: edge_cnt += rise every cycle. When gate_cnt==0 at an edge:
//     - count <= edge_cnt+rise (an edge on the final cycle is included);
//     - no_signal <= (that sum == 0);
//     - meas_valid=1 for the following cycle;
//     - edge_cnt restarts at 0, gate_cnt reloads. Windows run back-to-back with no dead cycle;
//   - en=0 in any state -> IDLE next cycle. A partial window is discarded: no meas_valid, count/no_signal hold.
//  Latency:
//   - en first sampled 1 at edge E;
//   - gate cycles are E+1..E+GATE_CYCLES;
//   - meas_valid is high in cycle E+GATE_CYCLES+1, then every GATE_CYCLES cycles.
//  Width: edge_cnt never exceeds GATE_CYCLES/2, so there is no count overflow (CNT_W rule above).
//  Period:
//   - p_cnt is CNT_W wide and increments every cycle while en=1, saturating at all-ones;
//   - on rise: p_cnt<=1;
//   - if armed: period<=p_cnt, period_ovf<=(p_cnt==all-ones), period_valid=1 next cycle;
//   - the first rise after en 0->1 or rst only arms; no period_valid;
//   - en=0 clears armed; period/period_ovf hold.
//  Simultaneous events: a rise on the window's last cycle counts in that window and also updates period.
//  meas_valid and period_valid may pulse in the same cycle.
//  Output timing: outputs registered; values stable between pulses.
// STRUCTURE
//  - No package types needed.
//  - FSM state encoding localparams ST_IDLE/ST_GATE live in the shared package, with other measurement-block states.
//  - One natural sub-module: sync_edge_detect (SYNC_STAGES synchronizer + rise pulse), reusable elsewhere.
//  - Gate counter, edge counter and period counter stay in freq_meter.
// TESTING  (GATE_CYCLES=64, CNT_W=8, SYNC_STAGES=2 unless noted)
//  1. sig_in = clk/4 square, en=1 from cycle 0:
//     - meas_valid every 64 cycles, first at cycle 65;
//     - count=16, no_signal=0;
//     - period=4 on every rise after the first.
//  2. sig_in = divide-by-3 pattern (1 high, 2 low):
//     - period=3 always;
//     - count in {21,22}; sum over 3 consecutive windows = 64.
//  3. sig_in held 0 (then held 1):
//     - count=0, no_signal=1;
//     - period_valid never asserts.
//  4. sig_in period 300 cycles:
//     - period=255, period_ovf=1;
//     - a subsequent period-4 input gives period=4, period_ovf=0.
//  5. en dropped at gate cycle 30, re-raised 5 cycles later:
//     - no meas_valid for the aborted window; count holds;
//     - next meas_valid at 65 cycles after re-enable edge;
//     - first rise after re-enable gives no period_valid.
//  6. rst pulsed mid-window with clk/4 input:
//     - all outputs 0 the next cycle;
//     - behaviour thereafter identical to test 1 from time zero.

Source files
------------

// File: rtl/freq_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : freq_meter_pkg
// Description : Shared constants for the on-chip measurement blocks. Holds the
//               common state encodings used by the frequency meter and its
//               sibling measurement blocks so that debug readback decodes the
//               same way everywhere.
// Revision    : 1.0 - initial release
// ============================================================================
package freq_meter_pkg;

  localparam int STATE_W = 2;

  // Measurement-block state encodings.
  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;  // not measuring
  localparam logic [STATE_W-1:0] ST_GATE = 2'd1;  // gate window running
  localparam logic [STATE_W-1:0] ST_ARM  = 2'd2;  // waiting for a trigger
  localparam logic [STATE_W-1:0] ST_HOLD = 2'd3;  // result frozen for readout

endpackage
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge_detect
// Description : Brings an asynchronous level into the clk domain through a
//               STAGES-deep flop chain, then flags each low->high transition
//               of the synchronized level with a one-cycle rise pulse.
// Ports       : clk       in  clock, rising edge
//               rst       in  synchronous active-high reset
//               sig_async in  asynchronous input level
//               rise      out one-cycle pulse per synchronized rising edge
// Revision    : 1.0 - initial release
// ============================================================================
module sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_async,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      // Bit 0 is the metastability-catching flop; the MSB is the clean level.
      sync_q <= {sync_q[STAGES-2:0], sig_async};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign rise = sync_q[STAGES-1] & ~hist_q;

endmodule
`default_nettype wire

// File: rtl/freq_meter.sv
`default_nettype none
// ============================================================================
// Module      : freq_meter
// Description : Measures a slow square wave in clk cycles. Produces a gated
//               edge count over back-to-back windows of GATE_CYCLES cycles and
//               the period between successive rising edges.
// Ports       : clk          in  clock, rising edge
//               rst          in  synchronous active-high reset
//               en           in  1 = measure, 0 = idle/abort
//               sig_in       in  asynchronous signal under test
//               count        out rising edges in last completed window
//               meas_valid   out 1-cycle pulse, count/no_signal updated
//               no_signal    out last completed window saw no edges
//               period       out clk cycles between last two rising edges
//               period_valid out 1-cycle pulse, period/period_ovf updated
//               period_ovf   out last period saturated at all-ones
// Revision    : 1.0 - initial release
// ============================================================================
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = 1024,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] count,
  output logic             meas_valid,
  output logic             no_signal,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             period_ovf
);

  localparam int               GATE_W    = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic               rise;
  logic [STATE_W-1:0] state;
  logic [GATE_W-1:0]  gate_cnt;
  logic [CNT_W-1:0]   edge_cnt;
  logic [CNT_W-1:0]   p_cnt;
  logic               armed;
  logic [CNT_W-1:0]   win_sum;

  sync_edge_detect #(
    .STAGES    (SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .rst       (rst),
    .sig_async (sig_in),
    .rise      (rise)
  );

  // Running count including this cycle's rise, so an edge on the final gate
  // cycle lands in the window that is closing.
  assign win_sum = edge_cnt + {{(CNT_W-1){1'b0}}, rise};

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      gate_cnt     <= '0;
      edge_cnt     <= '0;
      p_cnt        <= '0;
      armed        <= 1'b0;
      count        <= '0;
      meas_valid   <= 1'b0;
      no_signal    <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      period_ovf   <= 1'b0;
    end else begin
      meas_valid   <= 1'b0;
      period_valid <= 1'b0;

      if (!en) begin
        // Abort: a partial window is dropped and the results simply hold.
        state <= ST_IDLE;
        armed <= 1'b0;
        p_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            state    <= ST_GATE;
            edge_cnt <= '0;
            gate_cnt <= GATE_LOAD;
          end
          ST_GATE: begin
            if (gate_cnt == '0) begin
              count      <= win_sum;
              no_signal  <= (win_sum == '0);
              meas_valid <= 1'b1;
              // Next window starts on the very next cycle.
              edge_cnt   <= '0;
              gate_cnt   <= GATE_LOAD;
            end else begin
              edge_cnt <= win_sum;
              gate_cnt <= gate_cnt - GATE_W'(1);
            end
          end
          default: state <= ST_IDLE;
        endcase

        // Period: p_cnt counts cycles since the last rise; the first rise
        // after enabling has no reference edge, so it only arms.
        if (rise) begin
          p_cnt <= CNT_W'(1);
          armed <= 1'b1;
          if (armed) begin
            period       <= p_cnt;
            period_ovf   <= (p_cnt == CNT_MAX);
            period_valid <= 1'b1;
          end
        end else if (p_cnt != CNT_MAX) begin
          p_cnt <= p_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_freq_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_freq_meter
// Description : Self-checking bench for freq_meter (GATE_CYCLES=64, CNT_W=8,
//               SYNC_STAGES=2). Expected window and period results are queued
//               as stimulus is applied and compared when the DUT pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_freq_meter;

  localparam int GATE  = 64;
  localparam int CW    = 8;
  localparam int PMAX  = 255;

  logic          clk;
  logic          rst;
  logic          en;
  logic          sig_in;
  logic [CW-1:0] count;
  logic          meas_valid;
  logic          no_signal;
  logic [CW-1:0] period;
  logic          period_valid;
  logic          period_ovf;

  freq_meter #(
    .GATE_CYCLES  (GATE),
    .CNT_W        (CW),
    .SYNC_STAGES  (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .sig_in       (sig_in),
    .count        (count),
    .meas_valid   (meas_valid),
    .no_signal    (no_signal),
    .period       (period),
    .period_valid (period_valid),
    .period_ovf   (period_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int cnt;
    int ns;
    bit any;
  } meas_t;

  typedef struct {
    int p;
    int ovf;
  } per_t;

  meas_t q_meas[$];
  per_t  q_per[$];
  int    q_pend[$];   // edge index at which each driven rising edge reaches the DUT
  int    q_div3[$];

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit en_s     = 1'b0;
  bit rst_s    = 1'b1;

  // Signal generator controls (period 0 = constant level).
  int gen_p       = 0;
  int gen_h       = 0;
  bit gen_lvl     = 1'b0;
  bit gen_restart = 1'b0;
  bit div3_on     = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_sig(input int p, input int h);
    gen_p       = p;
    gen_h       = h;
    gen_restart = 1'b1;
  endtask

  task automatic set_level(input bit lvl);
    gen_p   = 0;
    gen_lvl = lvl;
  endtask

  // Expect n back-to-back windows after the enable edge e.
  task automatic push_win(input int e, input int n, input int cnt, input int ns, input bit any);
    for (int k = 1; k <= n; k++) q_meas.push_back('{e + GATE * k, cnt, ns, any});
  endtask

  task automatic chk_zero_outputs(input string pfx);
    chk({pfx, "_count"},        int'(count),        0);
    chk({pfx, "_meas_valid"},   int'(meas_valid),   0);
    chk({pfx, "_no_signal"},    int'(no_signal),    0);
    chk({pfx, "_period"},       int'(period),       0);
    chk({pfx, "_period_valid"}, int'(period_valid), 0);
    chk({pfx, "_period_ovf"},   int'(period_ovf),   0);
  endtask

  // Edge bookkeeping: cyc is the index of the edge just taken.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      en_s  = en;
      rst_s = rst;
    end
  end

  // Negative-edge process: drives sig_in, models the period expectations and
  // compares both result streams.
  initial begin
    int  ph;
    int  last_r;
    int  gap;
    bit  armed_m;
    bit  new_sig;
    bit  have_rise;
    bit  exp_pv;
    meas_t m;
    per_t  pe;
    ph      = 0;
    last_r  = 0;
    armed_m = 1'b0;
    sig_in  = 1'b0;
    forever begin
      @(negedge clk);
      if (gen_restart) begin
        ph          = 0;
        gen_restart = 1'b0;
      end
      if (gen_p == 0) begin
        new_sig = gen_lvl;
      end else begin
        new_sig = (ph < gen_h);
        ph      = (ph + 1 == gen_p) ? 0 : ph + 1;
      end
      // Two synchronizer flops plus the history flop: the rise is seen by the
      // DUT three edges after sig_in changes here.
      if (new_sig && !sig_in) q_pend.push_back(cyc + 3);
      sig_in = new_sig;

      while (q_pend.size() > 0 && q_pend[0] < cyc) void'(q_pend.pop_front());
      have_rise = (q_pend.size() > 0 && q_pend[0] == cyc);
      if (have_rise) void'(q_pend.pop_front());

      exp_pv = 1'b0;
      if (rst_s || !en_s) begin
        armed_m = 1'b0;
      end else if (have_rise) begin
        if (armed_m) begin
          gap = cyc - last_r;
          if (gap > PMAX) gap = PMAX;
          q_per.push_back('{gap, (gap == PMAX) ? 1 : 0});
          exp_pv = 1'b1;
        end
        armed_m = 1'b1;
        last_r  = cyc;
      end

      if (period_valid || exp_pv) begin
        chk("period_valid", int'(period_valid), int'(exp_pv));
        if (period_valid && q_per.size() > 0) begin
          pe = q_per.pop_front();
          chk("period", int'(period), pe.p);
          chk("period_ovf", int'(period_ovf), pe.ovf);
        end
      end

      if (meas_valid) begin
        if (q_meas.size() == 0) begin
          chk("meas_unexpected", 1, 0);
        end else begin
          m = q_meas.pop_front();
          chk("meas_time", cyc, m.cyc);
          if (!m.any) begin
            chk("count", int'(count), m.cnt);
            chk("no_signal", int'(no_signal), m.ns);
          end
          if (div3_on) q_div3.push_back(int'(count));
        end
      end else if (q_meas.size() > 0 && q_meas[0].cyc <= cyc) begin
        m = q_meas.pop_front();
        chk("meas_missing", 0, 1);
      end
    end
  end

  initial begin
    int e;
    int sum;
    rst = 1'b1;
    en  = 1'b0;
    set_level(1'b0);
    tick(3);
    chk_zero_outputs("reset");

    // 1: clk/4 input, enabled straight out of reset.
    rst = 1'b0;
    en  = 1'b1;
    set_sig(4, 2);
    e = cyc + 1;
    push_win(e, 3, 16, 0, 1'b0);
    tick(GATE * 3 + 4);
    chk("t1_count", int'(count), 16);
    chk("t1_period", int'(period), 4);
    en = 1'b0;

    // 2: divide-by-3 input, one cycle high.
    set_sig(3, 1);
    tick(6);
    div3_on = 1'b1;
    en = 1'b1;
    e = cyc + 1;
    push_win(e, 3, 0, 0, 1'b1);
    tick(GATE * 3 + 4);
    en = 1'b0;
    div3_on = 1'b0;
    chk("t2_windows", q_div3.size(), 3);
    sum = 0;
    foreach (q_div3[i]) begin
      chk("t2_count_range", int'(q_div3[i] == 21 || q_div3[i] == 22), 1);
      sum += q_div3[i];
    end
    chk("t2_sum3", sum, 64);

    // 3: input held low, then held high.
    set_level(1'b0);
    tick(6);
    en = 1'b1;
    e = cyc + 1;
    push_win(e, 2, 0, 1, 1'b0);
    tick(GATE * 2 + 4);
    en = 1'b0;
    set_level(1'b1);
    tick(6);
    en = 1'b1;
    e = cyc + 1;
    push_win(e, 2, 0, 1, 1'b0);
    tick(GATE * 2 + 4);
    en = 1'b0;

    // 4: 300-cycle period saturates, then a period-4 input recovers.
    set_sig(300, 150);
    tick(4);
    en = 1'b1;
    e = cyc + 1;
    push_win(e, 11, 0, 0, 1'b1);
    tick(620);
    chk("t4_period_sat", int'(period), 255);
    chk("t4_ovf_set", int'(period_ovf), 1);
    set_sig(4, 2);
    tick(GATE * 11 + 4 - 620);
    chk("t4_period_rec", int'(period), 4);
    chk("t4_ovf_clr", int'(period_ovf), 0);
    en = 1'b0;

    // 5: abort at gate cycle 30 of the second window, re-enable 5 later.
    set_sig(4, 2);
    tick(4);
    en = 1'b1;
    e = cyc + 1;
    push_win(e, 1, 16, 0, 1'b0);
    tick(GATE + 30 - 1);
    en = 1'b0;
    tick(5);
    chk("t5_count_hold", int'(count), 16);
    en = 1'b1;
    e = cyc + 1;
    push_win(e, 1, 16, 0, 1'b0);
    tick(GATE + 4);
    en = 1'b0;

    // 6: reset mid-window, then a clean restart like test 1.
    set_sig(4, 2);
    tick(4);
    en = 1'b1;
    tick(30);
    rst = 1'b1;
    set_level(1'b0);
    q_meas.delete();
    tick(1);
    chk_zero_outputs("t6_reset");
    tick(2);
    rst = 1'b0;
    set_sig(4, 2);
    e = cyc + 1;
    push_win(e, 2, 16, 0, 1'b0);
    tick(GATE * 2 + 4);
    chk("t6_count", int'(count), 16);
    en = 1'b0;

    tick(10);
    chk("meas_queue_empty", q_meas.size(), 0);
    chk("period_queue_empty", q_per.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
